instr_fetch: RTL

Instruction fetch stage of the five-stage in-order core: it owns the fetch PC, issues sequential word requests to instruction memory over a request/grant/response handshake, and buffers returned words in a small FIFO. It drains one entry per unstalled cycle into the IF/ID pipeline registers consumed by decode. A taken branch redirects the PC, flushes buffered and in-flight fetches, and injects a bubble (all-zero instruction word, which decode treats as a NOP).

---
 rtl/instr_fetch_pkg.sv | 35 +++
 rtl/fetch_fifo.sv | 77 +++++++
 rtl/instr_fetch.sv | 138 +++++++++++++
 3 files changed

// File: rtl/instr_fetch_pkg.sv
// Shared definitions for the fetch stage: bubble encoding, reset PC default,
// the buffered fetch entry layout and small PC helpers.
package instr_fetch_pkg;

    localparam logic [31:0] NOP_INST         = 32'h0000_0000;
    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

    // Major opcodes seen by decode; fetch itself never interprets them.
    typedef enum logic [6:0] {
        OP_LUI    = 7'b0110111,
        OP_AUIPC  = 7'b0010111,
        OP_JAL    = 7'b1101111,
        OP_JALR   = 7'b1100111,
        OP_BRANCH = 7'b1100011,
        OP_LOAD   = 7'b0000011,
        OP_STORE  = 7'b0100011,
        OP_IMM    = 7'b0010011,
        OP_REG    = 7'b0110011
    } opcode_e;

    // One buffered instruction together with the address it was fetched from.
    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
    } fetch_entry_t;

    function automatic logic [31:0] next_word(input logic [31:0] pc);
        return pc + 32'd4;
    endfunction

    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return addr & ~32'h0000_0003;
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous FIFO with wrap-around pointers and an occupancy count.
// Clear wins over push; a push into a full FIFO is accepted only alongside a pop.
module fetch_fifo #(
    parameter int unsigned WIDTH = 64,
    parameter int unsigned DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       clear,
    input  logic                       push,
    input  logic [WIDTH-1:0]           push_data,
    input  logic                       pop,
    output logic [WIDTH-1:0]           pop_data,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;
    localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             do_push;
    logic             do_pop;

    assign pop_data = mem_q[rd_ptr_q];
    assign count    = count_q;

    // Next-state for storage, pointers and occupancy.
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        do_pop   = pop && (count_q != '0);
        do_push  = push && ((count_q != FULL_COUNT) || do_pop);
        if (clear) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) begin
                mem_d[wr_ptr_q] = push_data;
                wr_ptr_d        = wr_ptr_q + AW'(1);
            end
            if (do_pop) begin
                rd_ptr_d = rd_ptr_q + AW'(1);
            end
            if (do_push && !do_pop) begin
                count_d = count_q + CW'(1);
            end else if (do_pop && !do_push) begin
                count_d = count_q - CW'(1);
            end
        end
    end

    // State register with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch stage: owns the fetch PC, issues credit-limited word
// requests, buffers responses and drains one entry per unstalled cycle into
// the IF/ID registers. A taken branch flushes and discards in-flight words.
module instr_fetch
    import instr_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = RESET_PC_DEFAULT,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic        CLK,
    input  logic        RESn,
    input  logic        HLT,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic [31:0] IF_ID_pc,
    output logic [31:0] IF_ID_inst
);

    localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;
    localparam logic [CW:0] DEPTH_SUM = (CW+1)'(FIFO_DEPTH);
    localparam int unsigned EW = $bits(fetch_entry_t);

    logic [31:0]   fetch_pc_q, fetch_pc_d;
    logic [31:0]   resp_pc_q, resp_pc_d;
    logic [CW-1:0] outstanding_q, outstanding_d;
    logic [CW-1:0] discard_q, discard_d;
    logic [31:0]   if_id_pc_q, if_id_pc_d;
    logic [31:0]   if_id_inst_q, if_id_inst_d;

    logic [CW-1:0] fifo_count;
    logic          fifo_push, fifo_pop, fifo_clear;
    fetch_entry_t  push_entry, pop_entry;
    logic [EW-1:0] pop_raw;
    logic [CW:0]   credit_used;
    logic          grant, rsp;

    assign pop_entry  = fetch_entry_t'(pop_raw);
    assign imem_addr  = fetch_pc_q;
    assign IF_ID_pc   = if_id_pc_q;
    assign IF_ID_inst = if_id_inst_q;

    fetch_fifo #(
        .WIDTH (EW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (CLK),
        .rst_n     (RESn),
        .clear     (fifo_clear),
        .push      (fifo_push),
        .push_data (push_entry),
        .pop       (fifo_pop),
        .pop_data  (pop_raw),
        .count     (fifo_count)
    );

    // Credit, request bookkeeping, response routing, redirect and drain.
    always_comb begin
        credit_used   = {1'b0, fifo_count} + {1'b0, outstanding_q};
        imem_req      = RESn && (credit_used < DEPTH_SUM);
        grant         = imem_req && imem_gnt;
        // A response with nothing owed is a protocol error and is ignored.
        rsp           = imem_rvalid && (outstanding_q != '0);

        fetch_pc_d    = fetch_pc_q;
        resp_pc_d     = resp_pc_q;
        outstanding_d = outstanding_q;
        discard_d     = discard_q;
        if_id_pc_d    = if_id_pc_q;
        if_id_inst_d  = if_id_inst_q;
        fifo_push     = 1'b0;
        fifo_pop      = 1'b0;
        fifo_clear    = 1'b0;
        push_entry    = '{pc: resp_pc_q, inst: imem_rdata};

        if (grant && !rsp) begin
            outstanding_d = outstanding_q + CW'(1);
        end else if (rsp && !grant) begin
            outstanding_d = outstanding_q - CW'(1);
        end

        if (grant) begin
            fetch_pc_d = next_word(fetch_pc_q);
        end

        if (branch_taken) begin
            // Everything still owed after this edge (including a grant made
            // this cycle) is dropped on return; this cycle's word is never pushed.
            fetch_pc_d   = word_align(branch_target);
            resp_pc_d    = word_align(branch_target);
            discard_d    = outstanding_d;
            fifo_clear   = 1'b1;
            if_id_inst_d = NOP_INST;
        end else begin
            if (rsp) begin
                if (discard_q != '0) begin
                    discard_d = discard_q - CW'(1);
                end else begin
                    fifo_push = 1'b1;
                    resp_pc_d = next_word(resp_pc_q);
                end
            end
            if (!HLT) begin
                if (fifo_count != '0) begin
                    fifo_pop     = 1'b1;
                    if_id_pc_d   = pop_entry.pc;
                    if_id_inst_d = pop_entry.inst;
                end else begin
                    if_id_inst_d = NOP_INST;
                end
            end
        end
    end

    // Fetch state and IF/ID registers, synchronous active-low reset.
    always_ff @(posedge CLK) begin
        if (!RESn) begin
            fetch_pc_q    <= RESET_PC;
            resp_pc_q     <= RESET_PC;
            outstanding_q <= '0;
            discard_q     <= '0;
            if_id_pc_q    <= '0;
            if_id_inst_q  <= NOP_INST;
        end else begin
            fetch_pc_q    <= fetch_pc_d;
            resp_pc_q     <= resp_pc_d;
            outstanding_q <= outstanding_d;
            discard_q     <= discard_d;
            if_id_pc_q    <= if_id_pc_d;
            if_id_inst_q  <= if_id_inst_d;
        end
    end

endmodule
